dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit between the memory stage and the data-memory bus. Takes the memory stage's registered read/write request and runs a req/gnt/rvalid bus transaction. Handles byte-lane steering, sign/zero extension, misalignment detection and a bus timeout. Returns `mem_ready` and formatted load data to the memory stage.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles spent in ISSUE+WAIT before abort; 8-bit counter.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_read` in 1: load request, level, from memory stage.
- `req_write` in 1: store request, level.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `load_sel` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes act as LW.
- `store_sel` in 2: 00 SB, 01 SH, 10 SW; 11 acts as SW.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: formatted load data; valid with `mem_ready`.
- `misaligned` out 1: pulses with `mem_ready` on a misaligned access.
- `bus_timeout` out 1: pulses with `mem_ready` on an aborted access.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 32: word address, `{req_addr[31:2],2'b00}`.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_be` out 4: byte enables.
- `dmem_gnt` in 1: request accepted.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: raw read word.

## Operation
- **State machine:** IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If `req_read|req_write`, capture addr, wdata, sel and op. Read wins if both are set.
  - Misaligned access goes to DONE with `misaligned`=1 and no bus activity. Misaligned means H with addr[0]=1, or W with addr[1:0]≠0.
  - Otherwise go to ISSUE.
- **ISSUE:**
  - `dmem_req`=1. Addr, we, wdata and be stay stable until `dmem_gnt`.
  - On gnt: a write goes to DONE; a read goes to WAIT.
- **WAIT:** on `dmem_rvalid`, register the formatted data, then go to DONE.
- **DONE:**
  - `mem_ready`=1 for exactly one cycle, then IDLE.
  - A request still high in the cycle after DONE is a new request. The upstream stage must drop or replace its request on seeing `mem_ready`.
- **Load format:**
  - Lane = addr[1:0] for bytes, addr[1] for halfwords.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Store steering:**
  - SB: byte replicated ×4, be=`4'b0001<<addr[1:0]`.
  - SH: halfword replicated ×2, be=`4'b0011<<{addr[1],1'b0}`.
  - SW: be=1111.
  - Reads drive be=1111.
- **Timeout:**
  - Counter clears on leaving IDLE and increments each cycle in ISSUE/WAIT.
  - When it reaches `TIMEOUT_CYCLES`: drop `dmem_req`, go to DONE with `bus_timeout`=1 and `mem_rdata`=0.
- **Stray bus responses:** `dmem_rvalid` outside WAIT is ignored, e.g. a late response after a timeout. `dmem_gnt` outside ISSUE is ignored.
- **Misaligned/timeout completions:** `mem_rdata`=0, no register write implied.

## Timing
- **Reset:** state IDLE, counter 0. All outputs 0 after the reset edge, including `dmem_addr`, `dmem_wdata` and `dmem_be`.
- **Reset mid-transaction:** the transaction is abandoned, `dmem_req` is 0 from the next cycle, and no `mem_ready` is produced.
- All outputs are registered, so nothing combinational reaches the bus.
- Request sampled at edge N: `dmem_req` high in cycle N+1.
- Read with gnt in N+1 and rvalid in N+2: `mem_ready` in N+3 (minimum read latency 3).
- Write with gnt in N+1: `mem_ready` in N+2 (minimum write latency 2).
- Misaligned access: `mem_ready` in N+1.
- Timeout: `mem_ready` `TIMEOUT_CYCLES`+2 cycles after N.
- Back-to-back operations: no overlap. The next request is sampled only in IDLE, giving one idle cycle between transactions.

## Structure
- **`rv32_pkg` additions:**
  - `lsu_state_t` enum (IDLE/ISSUE/WAIT/DONE).
  - Load constants `LS_LB/LS_LH/LS_LW/LS_LBU/LS_LHU`.
  - Store constants `SS_SB/SS_SH/SS_SW`.
- **Sub-module `lsu_align`:** purely combinational.
  - Store direction: (addr[1:0], store_sel, wdata) → (be, lane data).
  - Load direction: (addr[1:0], load_sel, rdata) → extended load data.
  - The FSM module instantiates it once and registers its outputs.

## Test plan
- LW addr 0x100, gnt in N+1, rvalid in N+2 with rdata 0xDEADBEEF → dmem_addr 0x100, `mem_ready`=1 in N+3, `mem_rdata`=0xDEADBEEF.
- LB addr 0x103 with rdata 0x80112233 → 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102 → 0x00008011.
- SB addr 0x201 wdata 0x000000AB → dmem_addr 0x200, be 0010, wdata 0xABABABAB, we=1; gnt delayed 3 cycles → req held stable, `mem_ready` the cycle after gnt.
- LW addr 0x102 → no `dmem_req`, `mem_ready`=`misaligned`=1 in N+1, `mem_rdata`=0. SH addr 0x301 → same.
- TIMEOUT_CYCLES=8, gnt never asserted → `dmem_req` drops, `bus_timeout`=`mem_ready`=1. Late rvalid afterwards is ignored.
- `reset` asserted while in WAIT → next cycle all outputs 0, state IDLE, no `mem_ready`. A fresh LW then completes normally.

Source files
------------

// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared types and constants for the data-memory load/store unit.
//   lsu_state_t : LSU transaction state (IDLE/ISSUE/WAIT/DONE)
//   LS_*        : load size/sign selector codes (load_sel)
//   SS_*        : store size selector codes (store_sel)
//   access_bytes: access width in bytes for a given op and selector
// -----------------------------------------------------------------------------
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LS_LB  = 3'b000;
    localparam logic [2:0] LS_LH  = 3'b001;
    localparam logic [2:0] LS_LW  = 3'b010;
    localparam logic [2:0] LS_LBU = 3'b100;
    localparam logic [2:0] LS_LHU = 3'b101;

    localparam logic [1:0] SS_SB = 2'b00;
    localparam logic [1:0] SS_SH = 2'b01;
    localparam logic [1:0] SS_SW = 2'b10;

    // Width of an access in bytes (1, 2 or 4). Unlisted codes are word accesses.
    function automatic logic [2:0] access_bytes(input logic       is_write,
                                                input logic [2:0] lsel,
                                                input logic [1:0] ssel);
        logic [2:0] nbytes;
        nbytes = 3'd4;
        if (is_write) begin
            case (ssel)
                SS_SB:   nbytes = 3'd1;
                SS_SH:   nbytes = 3'd2;
                default: nbytes = 3'd4;
            endcase
        end else begin
            case (lsel)
                LS_LB, LS_LBU: nbytes = 3'd1;
                LS_LH, LS_LHU: nbytes = 3'd2;
                default:       nbytes = 3'd4;
            endcase
        end
        return nbytes;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the load/store unit.
//   addr_lo_i    : byte offset within the word
//   is_write_i   : 1 = store access (selects which selector is used for size)
//   load_sel_i   : load selector (LB/LH/LW/LBU/LHU)
//   store_sel_i  : store selector (SB/SH/SW)
//   wdata_i      : LSB-aligned store data
//   rdata_i      : raw word read from the bus
//   be_o         : byte enables for a store
//   lane_wdata_o : store data replicated across all lanes
//   load_data_o  : extracted and sign/zero-extended load data
//   misaligned_o : access does not sit on its natural boundary
// -----------------------------------------------------------------------------
module lsu_align
    import rv32_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic        is_write_i,
    input  logic [2:0]  load_sel_i,
    input  logic [1:0]  store_sel_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] lane_wdata_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [7:0]  rbytes [4];
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [2:0]  nbytes;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rbytes
            assign rbytes[gi] = rdata_i[8*gi +: 8];
        end
    endgenerate

    assign rbyte  = rbytes[addr_lo_i];
    assign rhalf  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign nbytes = access_bytes(is_write_i, load_sel_i, store_sel_i);

    always_comb begin
        misaligned_o = 1'b0;
        case (nbytes)
            3'd2:    misaligned_o = addr_lo_i[0];
            3'd4:    misaligned_o = |addr_lo_i;
            default: misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        be_o         = 4'b1111;
        lane_wdata_o = wdata_i;
        case (store_sel_i)
            SS_SB: begin
                be_o         = 4'b0001 << addr_lo_i;
                lane_wdata_o = {4{wdata_i[7:0]}};
            end
            SS_SH: begin
                be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                lane_wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o         = 4'b1111;
                lane_wdata_o = wdata_i;
            end
        endcase
    end

    always_comb begin
        load_data_o = rdata_i;
        case (load_sel_i)
            LS_LB:   load_data_o = {{24{rbyte[7]}}, rbyte};
            LS_LH:   load_data_o = {{16{rhalf[15]}}, rhalf};
            LS_LBU:  load_data_o = {24'd0, rbyte};
            LS_LHU:  load_data_o = {16'd0, rhalf};
            default: load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit between the memory stage and a req/gnt/rvalid data bus.
//   clk, reset          : clock, synchronous active-high reset
//   req_read/req_write  : level requests from the memory stage (read wins)
//   req_addr/req_wdata  : byte address and LSB-aligned store data
//   load_sel/store_sel  : access size and sign selectors
//   mem_ready           : one-cycle completion pulse
//   mem_rdata           : formatted load data (0 for writes/misaligned/timeout)
//   misaligned          : completion was a rejected misaligned access
//   bus_timeout         : completion was an aborted bus access
//   dmem_*              : registered bus request side; dmem_gnt/rvalid/rdata in
// All outputs are registered.
// -----------------------------------------------------------------------------
module dmem_lsu
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  load_sel,
    input  logic [1:0]  store_sel,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        misaligned,
    output logic        bus_timeout,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  load_sel_q, load_sel_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        op_write_q, op_write_d;

    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        misaligned_q, misaligned_d;
    logic        bus_timeout_q, bus_timeout_d;

    logic        in_idle;
    logic [1:0]  align_addr_lo;
    logic [2:0]  align_load_sel;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load_data;
    logic        align_misaligned;
    logic        timeout_hit;

    // In IDLE the aligner looks at the live request (capture, steering and the
    // misalignment check); afterwards it formats the response using the
    // captured offset and selector.
    assign in_idle        = (state_q == IDLE);
    assign align_addr_lo  = in_idle ? req_addr[1:0] : addr_lo_q;
    assign align_load_sel = in_idle ? load_sel      : load_sel_q;
    assign timeout_hit    = (cnt_q == TO_LIMIT);

    lsu_align u_align (
        .addr_lo_i    (align_addr_lo),
        .is_write_i   (~req_read),
        .load_sel_i   (align_load_sel),
        .store_sel_i  (store_sel),
        .wdata_i      (req_wdata),
        .rdata_i      (dmem_rdata),
        .be_o         (align_be),
        .lane_wdata_o (align_wdata),
        .load_data_o  (align_load_data),
        .misaligned_o (align_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        load_sel_d    = load_sel_q;
        addr_lo_d     = addr_lo_q;
        op_write_d    = op_write_q;
        dmem_req_d    = dmem_req_q;
        dmem_we_d     = dmem_we_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        dmem_be_d     = dmem_be_q;
        mem_rdata_d   = mem_rdata_q;
        mem_ready_d   = 1'b0;
        misaligned_d  = 1'b0;
        bus_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_read || req_write) begin
                    cnt_d      = 8'd0;
                    load_sel_d = load_sel;
                    addr_lo_d  = req_addr[1:0];
                    op_write_d = ~req_read;
                    if (align_misaligned) begin
                        state_d      = DONE;
                        mem_ready_d  = 1'b1;
                        misaligned_d = 1'b1;
                        mem_rdata_d  = 32'd0;
                    end else begin
                        state_d      = ISSUE;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = ~req_read;
                        dmem_addr_d  = {req_addr[31:2], 2'b00};
                        dmem_be_d    = req_read ? 4'b1111 : align_be;
                        dmem_wdata_d = req_read ? 32'd0 : align_wdata;
                    end
                end
            end

            ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    if (op_write_q) begin
                        state_d     = DONE;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = 32'd0;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (timeout_hit) begin
                    dmem_req_d    = 1'b0;
                    state_d       = DONE;
                    mem_ready_d   = 1'b1;
                    bus_timeout_d = 1'b1;
                    mem_rdata_d   = 32'd0;
                end
            end

            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_rvalid) begin
                    state_d     = DONE;
                    mem_ready_d = 1'b1;
                    mem_rdata_d = align_load_data;
                end else if (timeout_hit) begin
                    state_d       = DONE;
                    mem_ready_d   = 1'b1;
                    bus_timeout_d = 1'b1;
                    mem_rdata_d   = 32'd0;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            load_sel_q    <= 3'd0;
            addr_lo_q     <= 2'd0;
            op_write_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= 32'd0;
            dmem_wdata_q  <= 32'd0;
            dmem_be_q     <= 4'd0;
            mem_ready_q   <= 1'b0;
            mem_rdata_q   <= 32'd0;
            misaligned_q  <= 1'b0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            load_sel_q    <= load_sel_d;
            addr_lo_q     <= addr_lo_d;
            op_write_q    <= op_write_d;
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            dmem_be_q     <= dmem_be_d;
            mem_ready_q   <= mem_ready_d;
            mem_rdata_q   <= mem_rdata_d;
            misaligned_q  <= misaligned_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    assign mem_ready   = mem_ready_q;
    assign mem_rdata   = mem_rdata_q;
    assign misaligned  = misaligned_q;
    assign bus_timeout = bus_timeout_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign dmem_be     = dmem_be_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Self-checking bench for dmem_lsu. The bench plays the memory stage and the
// bus slave, and predicts every output from the access rules: access width,
// natural alignment, lane extraction by shifting, and cycle-exact latencies.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  load_sel;
    logic [1:0]  store_sel;
    logic        mem_ready, misaligned, bus_timeout;
    logic [31:0] mem_rdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_read    (req_read),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .load_sel    (load_sel),
        .store_sel   (store_sel),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .misaligned  (misaligned),
        .bus_timeout (bus_timeout),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_be     (dmem_be),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int width_of(input bit is_read, input logic [2:0] lsel, input logic [1:0] ssel);
        if (is_read) begin
            if (lsel == 3'd0 || lsel == 3'd4) return 1;
            if (lsel == 3'd1 || lsel == 3'd5) return 2;
            return 4;
        end
        if (ssel == 2'd0) return 1;
        if (ssel == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] lsel, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (lsel)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "/mem_ready"},   32'(mem_ready),   32'd0);
        chk({tag, "/mem_rdata"},   mem_rdata,        32'd0);
        chk({tag, "/misaligned"},  32'(misaligned),  32'd0);
        chk({tag, "/bus_timeout"}, 32'(bus_timeout), 32'd0);
        chk({tag, "/dmem_req"},    32'(dmem_req),    32'd0);
        chk({tag, "/dmem_we"},     32'(dmem_we),     32'd0);
        chk({tag, "/dmem_addr"},   dmem_addr,        32'd0);
        chk({tag, "/dmem_wdata"},  dmem_wdata,       32'd0);
        chk({tag, "/dmem_be"},     32'(dmem_be),     32'd0);
    endtask

    // One complete access, with the bus slave granting after gdly cycles and
    // returning read data rdly cycles after the grant cycle.
    task automatic run_op(input string tag, input bit is_read, input bit both,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] lsel, input logic [1:0] ssel,
                          input int gdly, input int rdly, input logic [31:0] rdata);
        int          nb;
        bit          mis;
        logic [31:0] exp_be, exp_wd;
        nb     = width_of(is_read, lsel, ssel);
        mis    = (int'(addr[1:0]) % nb) != 0;
        exp_be = is_read ? 32'hF : (((32'd1 << nb) - 1) << addr[1:0]);
        exp_wd = (nb == 1) ? (wdata & 32'hFF) * 32'h01010101 :
                 (nb == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;

        req_read  = is_read;
        req_write = !is_read || both;
        req_addr  = addr;
        req_wdata = wdata;
        load_sel  = lsel;
        store_sel = ssel;
        tick();
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        load_sel  = 3'($urandom);
        store_sel = 2'($urandom);

        if (mis) begin
            chk({tag, "/mis_ready"}, 32'(mem_ready),   32'd1);
            chk({tag, "/mis_flag"},  32'(misaligned),  32'd1);
            chk({tag, "/mis_rdata"}, mem_rdata,        32'd0);
            chk({tag, "/mis_req"},   32'(dmem_req),    32'd0);
            chk({tag, "/mis_to"},    32'(bus_timeout), 32'd0);
            tick();
            chk({tag, "/mis_pulse"}, 32'(mem_ready),   32'd0);
            chk({tag, "/mis_req2"},  32'(dmem_req),    32'd0);
            $display("op %s: misaligned addr=%h", tag, addr);
            return;
        end

        chk({tag, "/req"},  32'(dmem_req), 32'd1);
        chk({tag, "/we"},   32'(dmem_we),  32'(!is_read));
        chk({tag, "/addr"}, dmem_addr,     addr & 32'hFFFF_FFFC);
        chk({tag, "/be"},   32'(dmem_be),  exp_be);
        if (!is_read) chk({tag, "/wdata"}, dmem_wdata, exp_wd);

        // Grant withheld: request must stay stable; stray rvalid is ignored.
        for (int i = 0; i < gdly; i++) begin
            dmem_rvalid = 1'($urandom);
            dmem_rdata  = $urandom;
            tick();
            chk({tag, "/hold_req"},   32'(dmem_req),  32'd1);
            chk({tag, "/hold_addr"},  dmem_addr,      addr & 32'hFFFF_FFFC);
            chk({tag, "/hold_be"},    32'(dmem_be),   exp_be);
            chk({tag, "/hold_ready"}, 32'(mem_ready), 32'd0);
        end
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b1;
        tick();
        dmem_gnt    = 1'b0;

        if (!is_read) begin
            chk({tag, "/w_ready"}, 32'(mem_ready),   32'd1);
            chk({tag, "/w_mis"},   32'(misaligned),  32'd0);
            chk({tag, "/w_to"},    32'(bus_timeout), 32'd0);
            chk({tag, "/w_req"},   32'(dmem_req),    32'd0);
        end else begin
            chk({tag, "/r_early"}, 32'(mem_ready), 32'd0);
            chk({tag, "/r_req"},   32'(dmem_req),  32'd0);
            for (int i = 0; i < rdly; i++) begin
                dmem_gnt = 1'($urandom);
                tick();
                chk({tag, "/r_wait"}, 32'(mem_ready), 32'd0);
            end
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b1;
            dmem_rdata  = rdata;
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            chk({tag, "/r_ready"}, 32'(mem_ready),   32'd1);
            chk({tag, "/r_data"},  mem_rdata,        exp_load(lsel, addr[1:0], rdata));
            chk({tag, "/r_to"},    32'(bus_timeout), 32'd0);
        end
        tick();
        chk({tag, "/pulse"}, 32'(mem_ready), 32'd0);
        $display("op %s: %s addr=%h sel=%0d gdly=%0d rdly=%0d", tag,
                 is_read ? "load" : "store", addr, is_read ? lsel : 3'(ssel), gdly, rdly);
    endtask

    // Aborted read: grant never (gcyc<0) or in cycle gcyc after the request, no rvalid.
    task automatic run_timeout(input string tag, input int gcyc);
        req_read = 1'b1;
        req_addr = 32'h0000_0400;
        load_sel = 3'd2;
        tick();
        req_read = 1'b0;
        for (int k = 1; k <= TO + 1; k++) begin
            chk({tag, "/to_ready"}, 32'(mem_ready), 32'd0);
            chk({tag, "/to_req"},   32'(dmem_req),  32'(gcyc < 0 || k <= gcyc));
            dmem_gnt = (k == gcyc);
            tick();
        end
        dmem_gnt = 1'b0;
        chk({tag, "/to_done"},  32'(mem_ready),   32'd1);
        chk({tag, "/to_flag"},  32'(bus_timeout), 32'd1);
        chk({tag, "/to_rdata"}, mem_rdata,        32'd0);
        chk({tag, "/to_req2"},  32'(dmem_req),    32'd0);
        chk({tag, "/to_mis"},   32'(misaligned),  32'd0);
        // Late response after the abort must be ignored.
        dmem_rvalid = 1'b1;
        dmem_gnt    = 1'b1;
        dmem_rdata  = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk({tag, "/late_ready"}, 32'(mem_ready), 32'd0);
            chk({tag, "/late_req"},   32'(dmem_req),  32'd0);
        end
        dmem_rvalid = 1'b0;
        dmem_gnt    = 1'b0;
        $display("op %s: timeout grant_cycle=%0d", tag, gcyc);
    endtask

    initial begin
        reset       = 1'b1;
        req_read    = 1'b0;
        req_write   = 1'b0;
        req_addr    = 32'd0;
        req_wdata   = 32'd0;
        load_sel    = 3'd0;
        store_sel   = 2'd0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");
        $display("op reset: outputs checked");

        // Directed accesses
        run_op("lw_100",  1, 0, 32'h100, 32'h0, 3'd2, 2'd0, 0, 0, 32'hDEADBEEF);
        run_op("lb_103",  1, 0, 32'h103, 32'h0, 3'd0, 2'd0, 0, 0, 32'h80112233);
        run_op("lbu_103", 1, 0, 32'h103, 32'h0, 3'd4, 2'd0, 1, 2, 32'h80112233);
        run_op("lhu_102", 1, 0, 32'h102, 32'h0, 3'd5, 2'd0, 0, 1, 32'h80112233);
        run_op("lh_102",  1, 1, 32'h102, 32'h0, 3'd1, 2'd0, 0, 0, 32'h80112233);
        run_op("sb_201",  0, 0, 32'h201, 32'hAB, 3'd0, 2'd0, 3, 0, 32'h0);
        run_op("sh_302",  0, 0, 32'h302, 32'h1234CDEF, 3'd0, 2'd1, 0, 0, 32'h0);
        run_op("sw_ss3",  0, 0, 32'h304, 32'hCAFEF00D, 3'd0, 2'd3, 2, 0, 32'h0);
        run_op("lw_102",  1, 0, 32'h102, 32'h0, 3'd2, 2'd0, 0, 0, 32'h0);
        run_op("sh_301",  0, 0, 32'h301, 32'h5555, 3'd0, 2'd1, 0, 0, 32'h0);

        // Timeouts: grant never, and grant followed by no rvalid
        run_timeout("to_nognt", -1);
        run_timeout("to_norv", 3);

        // Reset while waiting for read data
        req_read = 1'b1;
        req_addr = 32'h40;
        load_sel = 3'd2;
        tick();
        req_read = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check_all_zero("rst_wait");
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        tick();
        dmem_rvalid = 1'b0;
        chk("rst_wait/no_ready1", 32'(mem_ready), 32'd0);
        tick();
        chk("rst_wait/no_ready2", 32'(mem_ready), 32'd0);
        $display("op rst_wait: reset during WAIT checked");
        run_op("lw_after_rst", 1, 0, 32'h44, 32'h0, 3'd2, 2'd0, 0, 0, 32'h0BADF00D);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            run_op($sformatf("rnd%0d", n), 1'($urandom), 1'($urandom), $urandom, $urandom,
                   3'($urandom), 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
